// File: rtl/syscall_string_printer_if.sv
// Bundle of the print-string sequencer's signals: CPU start request,
// data-memory read port and console character sink.
interface syscall_string_printer_if;
    logic        start;
    logic [31:0] strAddr;
    logic [31:0] memAddr;
    logic        memRead;
    logic [31:0] memReadData;
    logic [7:0]  charOut;
    logic        charValid;
    logic        charReady;
    logic        busy;
    logic        done;
    logic        truncated;
    logic [15:0] charCount;

    // Environment side: CPU, data memory and console sink.
    modport master (
        output start, strAddr, memReadData, charReady,
        input  memAddr, memRead, charOut, charValid, busy, done, truncated, charCount
    );

    // Sequencer side.
    modport slave (
        input  start, strAddr, memReadData, charReady,
        output memAddr, memRead, charOut, charValid, busy, done, truncated, charCount
    );
endinterface

// File: rtl/syscall_string_printer.sv
// Print-string syscall sequencer: walks a null-terminated byte string in
// data memory one word at a time and hands characters to the console sink
// over a valid/ready handshake. Strings longer than MAX_LEN are cut short.
module syscall_string_printer #(
    parameter int MAX_LEN = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    syscall_string_printer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Compared against the widened count so MAX_LEN = 65535 needs no special case.
    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    state_t      state_q, state_d;
    logic [31:0] ptr_q,   ptr_d;     // byte address of the current character
    logic [31:0] word_q,  word_d;    // last fetched memory word
    logic [15:0] count_q, count_d;
    logic        trunc_q, trunc_d;

    logic [7:0]  cur_byte;
    logic [16:0] count_inc;

    // Little-endian byte lane picked by the low pointer bits; bytes below an
    // unaligned start offset are simply never selected.
    assign cur_byte  = word_q[{ptr_q[1:0], 3'b000} +: 8];
    assign count_inc = {1'b0, count_q} + 17'd1;

    // State register; reset abandons any string in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            word_q  <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
        end
    end

    // Next-state logic: fetch a word, emit its bytes, refetch at word boundary.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        count_d = count_q;
        trunc_d = trunc_q;
        case (state_q)
            S_IDLE: begin
                // start is ignored in every other state
                if (bus.start) begin
                    ptr_d   = bus.strAddr;
                    count_d = '0;
                    trunc_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                word_d  = bus.memReadData;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (cur_byte == 8'h00) begin
                    // terminator is consumed silently
                    state_d = S_DONE;
                end else if (bus.charReady) begin
                    ptr_d   = ptr_q + 32'd1;   // wraps modulo 2^32
                    count_d = count_inc[15:0];
                    if (count_inc == MAX_LEN_W) begin
                        // stop before touching the next word
                        trunc_d = 1'b1;
                        state_d = S_DONE;
                    end else if (ptr_q[1:0] == 2'b11) begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; charValid never looks at charReady,
    // so charOut stays put while the sink stalls.
    assign bus.memRead   = (state_q == S_FETCH);
    assign bus.memAddr   = {ptr_q[31:2], 2'b00};
    assign bus.charValid = (state_q == S_EMIT) && (cur_byte != 8'h00);
    assign bus.charOut   = bus.charValid ? cur_byte : 8'h00;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.truncated = trunc_q;
    assign bus.charCount = count_q;

endmodule

// File: tb/tb_syscall_string_printer.sv
// Scoreboard bench for syscall_string_printer: a byte-level reference model
// queues expected fetches, characters and completion results; a negedge
// monitor checks everything the DUT presents.
module tb_syscall_string_printer;

    localparam int MAXL = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    syscall_string_printer_if bus();

    syscall_string_printer #(.MAX_LEN(MAXL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 1 KB data memory, aliased over the whole address space.
    logic [31:0] mem [256];
    assign bus.memReadData = mem[bus.memAddr[9:2]];

    typedef struct {
        int unsigned cnt;
        bit          trunc;
        int unsigned lat;
        bit          chk_lat;
    } res_t;

    logic [7:0]  cq[$];
    logic [31:0] fq[$];
    res_t        rq[$];

    int          checks = 0;
    int          errors = 0;
    int unsigned tcyc = 0;
    int unsigned start_cyc = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit          done_seen = 1'b0;

    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    task automatic put_byte(input logic [31:0] a, input logic [7:0] b);
        mem[a[9:2]][{a[1:0], 3'b000} +: 8] = b;
    endtask

    // Reference: walk bytes from the start address until a null or MAXL chars.
    task automatic model(input logic [31:0] a, input bit chk_lat, input int unsigned extra);
        res_t        r;
        logic [31:0] p;
        logic [7:0]  b;
        int unsigned words;
        p     = a;
        words = 1;
        r.cnt = 0;
        r.trunc = 1'b0;
        fq.push_back({a[31:2], 2'b00});
        while (1) begin
            b = byte_at(p);
            if (b == 8'h00) break;
            cq.push_back(b);
            r.cnt++;
            if (r.cnt == MAXL) begin
                r.trunc = 1'b1;
                break;
            end
            p = p + 32'd1;
            if (p[1:0] == 2'b00) begin
                fq.push_back(p);
                words++;
            end
        end
        // start cycle + fetches + emitted chars + null cycle (if reached) + stalls
        r.lat     = 1 + words + r.cnt + (r.trunc ? 0 : 1) + extra;
        r.chk_lat = chk_lat;
        rq.push_back(r);
    endtask

    task automatic run(input logic [31:0] a, input bit chk_lat, input int unsigned extra);
        model(a, chk_lat, extra);
        @(posedge clk); #1;
        bus.strAddr = a;
        bus.start   = 1'b1;
        start_cyc   = tcyc;
        done_seen   = 1'b0;
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (done_seen) break;
        end
        chk("done_timeout", 32'(done_seen), 32'd1);
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_memRead"},   32'(bus.memRead),   32'd0);
        chk({tag, "_charValid"}, 32'(bus.charValid), 32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_done"},      32'(bus.done),      32'd0);
        chk({tag, "_truncated"}, 32'(bus.truncated), 32'd0);
        chk({tag, "_charCount"}, 32'(bus.charCount), 32'd0);
        chk({tag, "_charOut"},   32'(bus.charOut),   32'd0);
        chk({tag, "_memAddr"},   bus.memAddr,        32'd0);
    endtask

    // Sink handshake driver.
    initial begin
        bus.charReady = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       bus.charReady = 1'b1;
                2:       bus.charReady = 1'b0;
                default: bus.charReady = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: consumes expectations whenever the DUT presents an event.
    initial begin
        bit         prev_stall;
        bit         prev_done;
        logic [7:0] prev_char;
        res_t       r;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        prev_char  = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.charValid), 32'd1);
                chk("hold_char",  32'(bus.charOut),   32'(prev_char));
            end
            if (prev_done) chk("busy_after_done", 32'(bus.busy), 32'd0);
            if (bus.memRead) begin
                if (fq.size() == 0) chk("unexpected_fetch", bus.memAddr, 32'hxxxxxxxx);
                else                chk("fetch_addr", bus.memAddr, fq.pop_front());
            end
            if (bus.charValid && bus.charReady) begin
                if (cq.size() == 0) chk("unexpected_char", 32'(bus.charOut), 32'hxxxxxxxx);
                else                chk("char", 32'(bus.charOut), 32'(cq.pop_front()));
            end
            if (bus.done) begin
                chk("busy_in_done", 32'(bus.busy), 32'd1);
                if (rq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    r = rq.pop_front();
                    chk("charCount", 32'(bus.charCount), r.cnt);
                    chk("truncated", 32'(bus.truncated), 32'(r.trunc));
                    chk("chars_left", cq.size(), 32'd0);
                    chk("fetches_left", fq.size(), 32'd0);
                    if (r.chk_lat) chk("latency", tcyc - start_cyc, r.lat);
                end
                done_seen = 1'b1;
            end
            prev_stall = bus.charValid && !bus.charReady;
            prev_char  = bus.charOut;
            prev_done  = bus.done;
        end
    end

    // Stimulus.
    initial begin
        logic [31:0] a;
        int          len;
        bit          bp;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus.start   = 1'b0;
        bus.strAddr = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Aligned "Hi"
        mem[0] = 32'h0000_6948;
        run(32'h7FFF_FC00, 1'b1, 0);
        wait_done();

        // Unaligned, crossing a word: "ABCD"
        mem[0] = 32'h4342_4100;
        mem[1] = 32'h0000_0044;
        run(32'h7FFF_FC01, 1'b1, 0);
        wait_done();

        // Backpressure: 'H' held for three stalled cycles
        mem[0] = 32'h0000_6948;
        ready_mode = 2;
        run(32'h7FFF_FC00, 1'b1, 3);
        repeat (4) @(posedge clk);
        #1 ready_mode = 0;
        wait_done();

        // Empty string at an unaligned address
        mem[2] = 32'h4100_4342;
        run(32'h7FFF_FC0A, 1'b1, 0);
        wait_done();

        // Truncation: "ABCDEF" cut at MAXL
        mem[4] = 32'h4443_4241;
        mem[5] = 32'h0000_4645;
        run(32'h7FFF_FC10, 1'b1, 0);
        wait_done();

        // Address wrap past 0xFFFFFFFF
        put_byte(32'hFFFF_FFFE, 8'h78);
        put_byte(32'hFFFF_FFFF, 8'h79);
        put_byte(32'h0000_0000, 8'h7A);
        put_byte(32'h0000_0001, 8'h00);
        run(32'hFFFF_FFFE, 1'b1, 0);
        wait_done();

        // start while busy is ignored
        mem[8] = 32'h0000_4B4F;
        mem[4] = 32'h4443_4241;
        run(32'h7FFF_FC20, 1'b1, 0);
        @(posedge clk); #1;
        bus.strAddr = 32'h7FFF_FC10;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        wait_done();

        // Reset with charValid high, then restart from the first byte
        mem[10] = 32'h5352_5150;
        run(32'h7FFF_FC28, 1'b0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        cq.delete();
        fq.delete();
        rq.delete();
        @(posedge clk);
        @(negedge clk);
        check_zero("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        run(32'h7FFF_FC28, 1'b1, 0);
        wait_done();

        // Randomized strings, with and without sink backpressure
        for (int t = 0; t < 40; t++) begin
            a   = $urandom;
            len = $urandom_range(0, 7);
            for (int k = 0; k < len; k++) put_byte(a + 32'(k), 8'($urandom_range(1, 255)));
            put_byte(a + 32'(len), 8'h00);
            bp = ($urandom_range(0, 1) == 1);
            ready_mode = bp ? 1 : 0;
            run(a, !bp, 0);
            wait_done();
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/syscall_string_printer.md
# syscall_string_printer

Sequencer for the print-string syscall (`$v0 = 4`). On a start pulse it walks a null-terminated byte string in data memory starting at the address in `$a0`. It reads one 32-bit word at a time through the data memory read port and emits one character per accepted valid/ready handshake to the console sink. It sits directly upstream of data memory on the read side: it drives the read address and read enable, and consumes the read data. The CPU is stalled while `busy` is high.

## Interface
Parameters:
- `MAX_LEN`, default 256: maximum characters emitted per syscall before forced termination. Legal range 1..65535.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `strAddr`  in  32  byte address of first character (`$a0`); sampled with `start`.
- `memAddr`  out  32  word-aligned byte address to data memory (`{ptr[31:2],2'b00}`).
- `memRead`  out  1  read enable to data memory.
- `memReadData`  in  32  combinational read data from data memory.
- `charOut`  out  8  current character.
- `charValid`  out  1  `charOut` is valid.
- `charReady`  in  1  sink accepts the character this cycle.
- `busy`  out  1  high in FETCH, EMIT and DONE; the CPU stalls and gives memory port ownership to this block.
- `done`  out  1  one-cycle completion pulse.
- `truncated`  out  1  last string was cut at `MAX_LEN`. Sticky until the next accepted `start`.
- `charCount`  out  16  characters emitted by the last or current syscall.

## Operation
- State machine states:
  - IDLE: the only state in which `start` is sampled.
  - FETCH: exactly one cycle. Drives `memRead = 1` and `memAddr`. Latches `memReadData` into `wordBuf` at the clock edge.
  - EMIT: selects a byte from `wordBuf`; see byte selection and transitions below.
  - DONE: exactly one cycle. Asserts `done = 1`, then moves to IDLE.
- Byte selection (little-endian): the byte at `ptr` is `wordBuf[8*ptr[1:0] +: 8]`.
- IDLE transition: on `start`, load `ptr <= strAddr`, clear `charCount` and `truncated`, go to FETCH.
- EMIT transitions:
  - Selected byte is `8'h00`: go to DONE. `charValid` stays 0 and the null is never emitted.
  - Otherwise `charValid = 1` and `charOut = byte`. Hold while `charReady = 0`.
  - On `charValid && charReady`: `ptr <= ptr + 1`, `charCount <= charCount + 1`.
  - After that handshake, if the new count equals `MAX_LEN`: set `truncated`, go to DONE.
  - Else if the old `ptr[1:0] == 3`: go to FETCH.
  - Else stay in EMIT.
- Unaligned `strAddr`: the first fetch uses the aligned word. Bytes below the offset are skipped.
- `ptr` wraps modulo 2^32 with no error. Address range checking is the memory's responsibility.
- `start` while busy: ignored. The in-flight string is unaffected.
- The block never writes memory.
- Reset at any time (including mid-EMIT with `charValid` high):
  - Go to IDLE on the next edge.
  - `memRead = 0`, `charValid = 0`, `busy = 0`, `done = 0`, `truncated = 0`, `charCount = 0`, `charOut = 0`, `memAddr = 0`.
  - A partially emitted string is abandoned. There is no resume.

## Timing
- `charOut`, `charValid`, `memRead`, `memAddr` and `busy` are decoded from registered state, with no combinational path from inputs. Exception: `charValid` and `charOut` depend only on state, `ptr` and `wordBuf`, not on `charReady`.
- `charOut` is stable while `charValid = 1 && charReady = 0`.
- Latencies, with `charReady` tied high:
  - `start` at cycle 0 gives FETCH at cycle 1 and the first `charValid` at cycle 2.
  - One character per cycle within a word.
  - One FETCH bubble cycle per word boundary crossed.
  - The null byte costs one EMIT cycle, then DONE.
  - Total cycles from `start` to `done` = 1 + words fetched + chars emitted + 1, when the string is null-terminated.
- `memRead` is high only in FETCH, exactly one cycle per word.
- `done` pulses in the cycle before `busy` falls. `busy` is low in the cycle after DONE.
- `charCount` saturates at `MAX_LEN`. It holds its value after DONE until the next `start`.

## Test plan
- **Aligned "Hi":**
  - Stimulus: memory word at `0x7FFFFC00` = `0x00006948`, `strAddr = 0x7FFFFC00`, `charReady = 1`, `start` at cycle 0.
  - Required: `charOut` = `0x48` (cycle 2), then `0x69` (cycle 3); `done` at cycle 5; `charCount = 2`; `memRead` high only at cycle 1.
- **Unaligned, word-crossing:**
  - Stimulus: `0x7FFFFC00` = `0x43424100`, `0x7FFFFC04` = `0x00000044`, `strAddr = 0x7FFFFC01`.
  - Required: emits "ABCD"; exactly 2 fetches with `memAddr` `0x7FFFFC00` then `0x7FFFFC04`; one bubble between `'C'` and `'D'`; `charCount = 4`.
- **Backpressure:**
  - Stimulus: as the "Hi" case, but `charReady = 0` for 3 cycles while `'H'` is valid.
  - Required: `charOut` holds `0x48` with `charValid = 1` through the stall; `'i'` follows the cycle after acceptance; no extra `memRead`.
- **Empty string:**
  - Stimulus: the byte at `strAddr` is `0x00`.
  - Required: `charValid` never asserts; `done` at cycle 3; `charCount = 0`.
- **Truncation with `MAX_LEN = 4`:**
  - Stimulus: string "ABCDEF\0".
  - Required: exactly 4 characters "ABCD"; `truncated = 1`; `done` pulses; no fetch of the second word.
- **Reset mid-EMIT and busy-time `start`:**
  - Stimulus: a `start` pulse during EMIT.
  - Required: the in-flight string is unaffected.
  - Stimulus: `reset` asserted with `charValid` high.
  - Required: on the next cycle all outputs are 0 and the state is IDLE.
  - Stimulus: a new `start` after reset.
  - Required: the string prints correctly from its first byte.
